// File: rtl/mux_pkt_arb_if.sv
// Handshake bundle between the 2:1 flit mux inputs, the downstream credit
// return and the packet arbiter that sequences them.
interface mux_pkt_arb_if #(
  parameter int TYPEW = 2,
  parameter int PORTW = 5,
  parameter int CNTW  = 3
);
  logic             ivalid_0;
  logic [TYPEW-1:0] itype_0;
  logic             ivalid_1;
  logic [TYPEW-1:0] itype_1;
  logic             icredit;
  logic [PORTW-1:0] sel;
  logic             iack_0;
  logic             iack_1;
  logic             ovalid;
  logic [CNTW-1:0]  credit;
  logic             busy;
  logic             err;

  // Master sources flits and credit returns; slave is the arbiter.
  modport master (
    output ivalid_0, itype_0, ivalid_1, itype_1, icredit,
    input  sel, iack_0, iack_1, ovalid, credit, busy, err
  );

  modport slave (
    input  ivalid_0, itype_0, ivalid_1, itype_1, icredit,
    output sel, iack_0, iack_1, ovalid, credit, busy, err
  );
endinterface

// File: rtl/mux_pkt_arb.sv
// Packet-level round-robin arbiter for a 2:1 flit mux: locks the output from
// HEAD to TAIL and only forwards while downstream credit is available.
module mux_pkt_arb #(
  parameter int TYPEW   = 2,
  parameter int PORTW   = 5,
  parameter int CREDITS = 4,
  parameter int CNTW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mux_pkt_arb_if.slave   bus
);

  localparam logic [TYPEW-1:0] T_HEAD     = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL     = TYPEW'(3);
  localparam logic [CNTW-1:0]  CREDIT_MAX = CNTW'(CREDITS);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t          state, state_next;
  logic            rr_ptr, rr_next;
  logic [CNTW-1:0] credit_q, credit_next;
  logic            err_q, err_next;
  logic [1:0]      grant;
  logic            cand0, cand1, winner, fwd_ok, proto_err, ovalid;

  assign fwd_ok = (credit_q != '0);
  assign cand0  = bus.ivalid_0 && (bus.itype_0 == T_HEAD);
  assign cand1  = bus.ivalid_1 && (bus.itype_1 == T_HEAD);
  assign ovalid = |grant;

  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    grant      = 2'b00;
    proto_err  = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: begin
        winner = (cand0 && cand1) ? rr_ptr : cand1;
        if ((cand0 || cand1) && fwd_ok) begin
          grant      = winner ? 2'b10 : 2'b01;
          state_next = winner ? LOCK1 : LOCK0;
        end
        if ((bus.ivalid_0 && !cand0) || (bus.ivalid_1 && !cand1))
          proto_err = 1'b1;
      end
      LOCK0: begin
        if (bus.ivalid_0) begin
          if (bus.itype_0 == T_HEAD) begin
            proto_err = 1'b1;
          end else if (fwd_ok) begin
            grant = 2'b01;
            if (bus.itype_0 == T_TAIL) begin
              state_next = IDLE;
              rr_next    = 1'b1;
            end
          end
        end
      end
      LOCK1: begin
        if (bus.ivalid_1) begin
          if (bus.itype_1 == T_HEAD) begin
            proto_err = 1'b1;
          end else if (fwd_ok) begin
            grant = 2'b10;
            if (bus.itype_1 == T_TAIL) begin
              state_next = IDLE;
              rr_next    = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are combinational, so they must be forced quiet while reset is held.
    if (rst) grant = 2'b00;
  end

  // A forward and a returned credit in the same cycle cancel out.
  always_comb begin
    credit_next = credit_q;
    err_next    = err_q | proto_err;
    if (ovalid && !bus.icredit) begin
      credit_next = credit_q - CNTW'(1);
    end else if (bus.icredit && !ovalid) begin
      if (credit_q == CREDIT_MAX) err_next = 1'b1;
      else                        credit_next = credit_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      credit_q <= CREDIT_MAX;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      credit_q <= credit_next;
      err_q    <= err_next;
    end
  end

  assign bus.sel    = PORTW'(grant);
  assign bus.iack_0 = grant[0];
  assign bus.iack_1 = grant[1];
  assign bus.ovalid = ovalid;
  assign bus.credit = credit_q;
  assign bus.busy   = (state != IDLE);
  assign bus.err    = err_q;

endmodule
